// File: rtl/riscv_pkg.sv
// Shared load/store encodings, LSU state type and lane helpers.
// Pure definitions: no latency, no backpressure.
package riscv_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic {LSU_IDLE, LSU_BUSY} lsu_state_t;

  // Legal size for the direction and naturally aligned for the access width.
  function automatic logic ldst_legal(input logic [2:0] size, input logic we, input logic [1:0] off);
    logic ok;
    case (size)
      LDST_B:  ok = 1'b1;
      LDST_BU: ok = ~we;
      LDST_H:  ok = ~off[0];
      LDST_HU: ok = ~we & ~off[0];
      LDST_W:  ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      LDST_B:  be = 4'b0001 << off;
      LDST_H:  be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wd(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      LDST_B:  d = {4{wd[7:0]}};
      LDST_H:  d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_riscv_if.sv
// Data-memory port: registered request side from the LSU, read data/ready back.
// Single outstanding transaction; ready completes it, no separate grant.
interface lsu_riscv_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;

  modport master (output req, we, be, addr, wd, input rd, ready);
  modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/lsu_load_formatter.sv
// Extracts the addressed byte/half from a 32-bit read word and sign/zero-extends it.
// Combinational, zero latency, no backpressure.
module lsu_load_formatter
  import riscv_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = mem_rd[7:0];
      2'd1:    byte_sel = mem_rd[15:8];
      2'd2:    byte_sel = mem_rd[23:16];
      default: byte_sel = mem_rd[31:24];
    endcase
    half_sel = offset[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size)
      LDST_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: load_data = {24'd0, byte_sel};
      LDST_H:  load_data = {{16{half_sel[15]}}, half_sel};
      LDST_HU: load_data = {16'd0, half_sel};
      default: load_data = mem_rd;
    endcase
  end

endmodule

// File: rtl/lsu_riscv.sv
// Load/store unit: one handshaked data-memory access per core request, formatted load return.
// Min 2 cycles req->done; stalls the core until ready or timeout, illegal accesses never stall.
module lsu_riscv
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [31:0]       core_addr_i,
  input  logic [31:0]       core_wd_i,
  output logic [31:0]       core_rd_o,
  output logic              core_stall_o,
  output logic              misaligned_o,
  output logic              bus_err_o,
  lsu_riscv_if.master       mem
);

  localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state;
  logic [TW-1:0] timer;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] rd_q;
  logic [31:0] fmt_data;
  logic        legal, busy, timeout, done;

  lsu_load_formatter u_fmt (
    .mem_rd    (mem.rd),
    .offset    (off_q),
    .size      (size_q),
    .load_data (fmt_data)
  );

  assign legal   = ldst_legal(core_size_i, core_we_i, core_addr_i[1:0]);
  assign busy    = (state == LSU_BUSY);
  assign timeout = (TIMEOUT_CYCLES != 0) && (timer == TLAST);
  assign done    = busy & (mem.ready | timeout);

  // Gated by rst_ni so every output reads 0 while reset is asserted.
  assign misaligned_o = rst_ni & ~busy & core_req_i & ~legal;
  assign bus_err_o    = rst_ni & busy & timeout & ~mem.ready;
  assign core_stall_o = rst_ni & core_req_i & ~done & ~(~busy & ~legal);
  assign core_rd_o    = (busy & mem.ready) ? fmt_data : rd_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= LSU_IDLE;
      timer    <= '0;
      size_q   <= '0;
      off_q    <= '0;
      rd_q     <= '0;
      mem.req  <= 1'b0;
      mem.we   <= 1'b0;
      mem.be   <= '0;
      mem.addr <= '0;
      mem.wd   <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (core_req_i && legal) begin
            state    <= LSU_BUSY;
            timer    <= '0;
            size_q   <= core_size_i;
            off_q    <= core_addr_i[1:0];
            mem.req  <= 1'b1;
            mem.we   <= core_we_i;
            mem.be   <= core_we_i ? store_be(core_size_i, core_addr_i[1:0]) : 4'b1111;
            mem.addr <= core_addr_i;
            mem.wd   <= core_we_i ? store_wd(core_size_i, core_wd_i) : 32'd0;
          end
        end
        LSU_BUSY: begin
          if (done) begin
            state   <= LSU_IDLE;
            mem.req <= 1'b0;
            if (mem.ready && !mem.we) rd_q <= fmt_data;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed-vector bench for lsu_riscv with a 4-cycle bus timeout.
module tb_lsu_riscv;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o, misaligned_o, bus_err_o;

  int n_vec = 0;
  int n_err = 0;

  lsu_riscv_if mem ();

  lsu_riscv #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .misaligned_o (misaligned_o),
    .bus_err_o    (bus_err_o),
    .mem          (mem)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
  endtask

  // Access completed by ready one cycle after the request enters BUSY.
  task automatic txn(input string tag, input logic we, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                     input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    @(posedge clk_i); #1;
    drive_req(we, size, addr, wd);
    mem.ready = 1'b0;
    @(negedge clk_i);
    chk_val({tag, "_stall_idle"}, {31'd0, core_stall_o}, 32'd1);
    chk_val({tag, "_req_idle"}, {31'd0, mem.req}, 32'd0);
    @(posedge clk_i); #1;
    mem.ready = 1'b1;
    mem.rd    = rd;
    @(negedge clk_i);
    chk_val({tag, "_req"}, {31'd0, mem.req}, 32'd1);
    chk_val({tag, "_we"}, {31'd0, mem.we}, {31'd0, we});
    chk_val({tag, "_be"}, {28'd0, mem.be}, {28'd0, exp_be});
    chk_val({tag, "_addr"}, mem.addr, addr);
    chk_val({tag, "_stall_done"}, {31'd0, core_stall_o}, 32'd0);
    if (we) chk_val({tag, "_wd"}, mem.wd, exp_wd);
    else    chk_val({tag, "_rd"}, core_rd_o, exp_rd);
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
    mem.ready  = 1'b0;
    mem.rd     = 32'd0;
    @(negedge clk_i);
    chk_val({tag, "_req_drop"}, {31'd0, mem.req}, 32'd0);
    if (!we) chk_val({tag, "_rd_hold"}, core_rd_o, exp_rd);
  endtask

  task automatic illegal(input string tag, input logic we, input logic [2:0] size,
                         input logic [31:0] addr);
    @(posedge clk_i); #1;
    drive_req(we, size, addr, 32'hA5A5A5A5);
    @(negedge clk_i);
    chk_val({tag, "_mis"}, {31'd0, misaligned_o}, 32'd1);
    chk_val({tag, "_stall"}, {31'd0, core_stall_o}, 32'd0);
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
    @(negedge clk_i);
    chk_val({tag, "_req"}, {31'd0, mem.req}, 32'd0);
    chk_val({tag, "_mis_clr"}, {31'd0, misaligned_o}, 32'd0);
  endtask

  // Holds the request with no ready; ready_at (0 = never) asserts ready in that BUSY cycle.
  task automatic stall_run(input string tag, input int ready_at, input logic [31:0] rd);
    @(posedge clk_i); #1;
    drive_req(1'b0, LDST_W, 32'h0000_0300, 32'd0);
    mem.ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk_i); #1;
      if (i == ready_at) begin
        mem.ready = 1'b1;
        mem.rd    = rd;
      end
      @(negedge clk_i);
      chk_val($sformatf("%s_req_c%0d", tag, i), {31'd0, mem.req}, 32'd1);
      chk_val($sformatf("%s_err_c%0d", tag, i), {31'd0, bus_err_o},
              {31'd0, (i == 4) && (ready_at != 4)});
      chk_val($sformatf("%s_stall_c%0d", tag, i), {31'd0, core_stall_o}, {31'd0, i != 4});
    end
    if (ready_at == 4) chk_val({tag, "_rd"}, core_rd_o, rd);
    @(posedge clk_i); #1;
    core_req_i = 1'b0;
    mem.ready  = 1'b0;
    @(negedge clk_i);
    chk_val({tag, "_req_drop"}, {31'd0, mem.req}, 32'd0);
    chk_val({tag, "_err_clr"}, {31'd0, bus_err_o}, 32'd0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'd0;
    core_wd_i   = 32'd0;
    mem.rd      = 32'd0;
    mem.ready   = 1'b0;
    #12;
    chk_val("rst_req", {31'd0, mem.req}, 32'd0);
    chk_val("rst_stall", {31'd0, core_stall_o}, 32'd0);
    chk_val("rst_rd", core_rd_o, 32'd0);
    chk_val("rst_err", {30'd0, bus_err_o, misaligned_o}, 32'd0);
    rst_ni = 1'b1;

    txn("lw",  1'b0, LDST_W,  32'h0000_0100, 32'd0, 32'hDEADBEEF, 4'b1111, 32'd0, 32'hDEADBEEF);
    txn("lb",  1'b0, LDST_B,  32'h0000_0103, 32'd0, 32'h80FF_0000, 4'b1111, 32'd0, 32'hFFFFFF80);
    txn("lbu", 1'b0, LDST_BU, 32'h0000_0103, 32'd0, 32'h80FF_0000, 4'b1111, 32'd0, 32'h00000080);
    txn("lhu", 1'b0, LDST_HU, 32'h0000_0102, 32'd0, 32'h80FF_0000, 4'b1111, 32'd0, 32'h000080FF);
    txn("lh",  1'b0, LDST_H,  32'h0000_0102, 32'd0, 32'h80FF_0000, 4'b1111, 32'd0, 32'hFFFF80FF);
    txn("lh0", 1'b0, LDST_H,  32'h0000_0100, 32'd0, 32'h80FF_1234, 4'b1111, 32'd0, 32'h00001234);
    txn("sb",  1'b1, LDST_B,  32'h0000_0201, 32'h12345678, 32'd0, 4'b0010, 32'h78787878, 32'd0);
    txn("sh",  1'b1, LDST_H,  32'h0000_0202, 32'h12345678, 32'd0, 4'b1100, 32'h56785678, 32'd0);
    txn("sw",  1'b1, LDST_W,  32'h0000_0204, 32'h12345678, 32'd0, 4'b1111, 32'h12345678, 32'd0);

    illegal("lw_mis", 1'b0, LDST_W, 32'h0000_0102);
    illegal("sh_mis", 1'b1, LDST_H, 32'h0000_0201);
    illegal("sbu",    1'b1, LDST_BU, 32'h0000_0200);
    illegal("sz3",    1'b0, 3'b011, 32'h0000_0200);

    stall_run("tmo", 0, 32'd0);
    stall_run("coin", 4, 32'h11223344);

    // Reset while BUSY abandons the access; ready afterwards must be ignored.
    @(posedge clk_i); #1;
    drive_req(1'b0, LDST_W, 32'h0000_0500, 32'd0);
    @(posedge clk_i); #1;
    chk_val("mid_req", {31'd0, mem.req}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk_val("mid_rst_req", {31'd0, mem.req}, 32'd0);
    chk_val("mid_rst_stall", {31'd0, core_stall_o}, 32'd0);
    chk_val("mid_rst_rd", core_rd_o, 32'd0);
    chk_val("mid_rst_be", {28'd0, mem.be}, 32'd0);
    core_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    mem.ready = 1'b1;
    mem.rd    = 32'hCAFEF00D;
    @(negedge clk_i);
    chk_val("idle_rdy_req", {31'd0, mem.req}, 32'd0);
    chk_val("idle_rdy_rd", core_rd_o, 32'd0);
    chk_val("idle_rdy_err", {31'd0, bus_err_o}, 32'd0);
    @(posedge clk_i); #1;
    mem.ready = 1'b0;
    @(negedge clk_i);
    chk_val("idle_rdy_hold", core_rd_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
